// File: rtl/i2c_eeprom_slave.sv
// i2c_eeprom_slave: I2C target emulating a 24LC64-class serial EEPROM.
// Ports: clk, rst (sync, active-high), scl_i/sda_i bus levels,
//   sda_oe (1 = pull SDA low), addr_pins strap, wp write protect,
//   wr_pulse (one cycle per committed write), ptr (address pointer).
// Optional macro WR_BUSY_EN: NACK the device address for BUSY_CYCLES
//   clocks after a STOP that ends a transaction containing writes.
module i2c_eeprom_slave #(
  parameter logic [3:0] DEV_ID      = 4'b1010,
  parameter int         ADDR_W      = 13,
  parameter int         PAGE_SIZE   = 32,
  parameter int         BUSY_CYCLES = 5000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  input  logic [2:0]        addr_pins,
  input  logic              wp,
  output logic              wr_pulse,
  output logic [ADDR_W-1:0] ptr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PMASK = ADDR_W'(PAGE_SIZE - 1);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, ADRH, ADRH_ACK, ADRL, ADRL_ACK,
    WDAT, WDAT_ACK, RDAT, RDAT_ACK, WAIT_STOP
  } state_t;

  state_t              state;
  logic [1:0]          scl_sync;
  logic [1:0]          sda_sync;
  logic                scl_d;
  logic                sda_d;
  logic [3:0]          bit_cnt;
  logic [6:0]          sh;
  logic [ADDR_W-9:0]   adrh;
  logic [7:0]          rd_byte;
  logic                phase;
  logic                rnw;
  logic [7:0]          mem [DEPTH];

  logic                scl_s;
  logic                sda_s;
  logic                scl_rise;
  logic                scl_fall;
  logic                start_det;
  logic                stop_det;
  logic [7:0]          byte_in;
  logic                commit;
  logic                busy;
  logic [6:0]          dev_addr;
  logic [ADDR_W-1:0]   page_next;

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  // SDA edges only count as START/STOP while SCL stays high
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign byte_in   = {sh, sda_s};
  assign dev_addr  = {DEV_ID, addr_pins};
  assign commit    = (state == WDAT) & scl_rise & (bit_cnt == 4'd7) & ~wp;
  // page write: only the in-page offset advances
  assign page_next = (ptr & ~PMASK) | ((ptr + ADDR_W'(1)) & PMASK);

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

`ifdef WR_BUSY_EN
  localparam int BW = $clog2(BUSY_CYCLES + 1);
  logic [BW-1:0] busy_cnt;
  logic          wrote;

  assign busy = (busy_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt <= '0;
      wrote    <= 1'b0;
    end else begin
      if (stop_det) begin
        wrote <= 1'b0;
      end else if (commit) begin
        wrote <= 1'b1;
      end
      if (stop_det && wrote) begin
        busy_cnt <= BW'(BUSY_CYCLES);
      end else if (busy) begin
        busy_cnt <= busy_cnt - BW'(1);
      end
    end
  end
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (commit && !rst) begin
      mem[ptr] <= byte_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sda_oe   <= 1'b0;
      wr_pulse <= 1'b0;
      ptr      <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      adrh     <= '0;
      rd_byte  <= '0;
      phase    <= 1'b0;
      rnw      <= 1'b0;
    end else begin
      wr_pulse <= commit;
      if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        phase  <= 1'b0;
      end else if (start_det) begin
        state   <= DEV;
        bit_cnt <= '0;
        phase   <= 1'b0;
        sda_oe  <= 1'b0;
      end else begin
        case (state)
          DEV, ADRH, ADRL, WDAT: begin
            if (scl_rise) begin
              sh      <= byte_in[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                phase   <= 1'b0;
                case (state)
                  DEV: begin
                    rnw   <= sda_s;
                    state <= (sh == dev_addr && !busy) ?
                             DEV_ACK : WAIT_STOP;
                  end
                  ADRH: begin
                    adrh  <= byte_in[ADDR_W-9:0];
                    state <= ADRH_ACK;
                  end
                  ADRL: begin
                    ptr   <= {adrh, byte_in};
                    state <= ADRL_ACK;
                  end
                  default: begin
                    if (wp) begin
                      state <= WAIT_STOP;
                    end else begin
                      ptr   <= page_next;
                      state <= WDAT_ACK;
                    end
                  end
                endcase
              end
            end
          end
          DEV_ACK, ADRH_ACK, ADRL_ACK, WDAT_ACK: begin
            // first fall asserts ACK, second fall ends it
            if (scl_fall) begin
              if (!phase) begin
                sda_oe <= 1'b1;
                phase  <= 1'b1;
              end else begin
                phase  <= 1'b0;
                sda_oe <= 1'b0;
                case (state)
                  DEV_ACK: begin
                    if (rnw) begin
                      state   <= RDAT;
                      rd_byte <= mem[ptr];
                      sda_oe  <= ~mem[ptr][7];
                      bit_cnt <= '0;
                    end else begin
                      state <= ADRH;
                    end
                  end
                  ADRH_ACK: state <= ADRL;
                  default:  state <= WDAT;
                endcase
              end
            end
          end
          RDAT: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                phase  <= 1'b0;
                state  <= RDAT_ACK;
              end else begin
                sda_oe <= ~rd_byte[3'd7 - bit_cnt[2:0]];
              end
            end
          end
          RDAT_ACK: begin
            if (scl_rise) begin
              ptr <= ptr + ADDR_W'(1);
              if (sda_s) begin
                state <= WAIT_STOP;
              end else begin
                phase <= 1'b1;
              end
            end
            if (scl_fall && phase) begin
              phase   <= 1'b0;
              state   <= RDAT;
              rd_byte <= mem[ptr];
              sda_oe  <= ~mem[ptr][7];
              bit_cnt <= '0;
            end
          end
          default: begin
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// tb_i2c_eeprom_slave: bus-level master driving i2c_eeprom_slave,
// checked against a byte-array model of the EEPROM.
module tb_i2c_eeprom_slave;

  localparam int ADDR_W = 13;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int PAGE   = 32;
  localparam int BUSY   = 200;
  localparam int Q      = 40;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              scl = 1'b1;
  logic              sda_drv = 1'b1;
  logic              sda_oe;
  logic [2:0]        addr_pins = 3'b000;
  logic              wp = 1'b0;
  logic              wr_pulse;
  logic [ADDR_W-1:0] ptr;
  logic              sda_bus;

  assign sda_bus = sda_drv & ~sda_oe;

  i2c_eeprom_slave #(
    .DEV_ID(4'b1010),
    .ADDR_W(ADDR_W),
    .PAGE_SIZE(PAGE),
    .BUSY_CYCLES(BUSY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .scl_i(scl),
    .sda_i(sda_bus),
    .sda_oe(sda_oe),
    .addr_pins(addr_pins),
    .wp(wp),
    .wr_pulse(wr_pulse),
    .ptr(ptr)
  );

  always #5 clk = ~clk;

  int pulses = 0;
  int oe_cycles = 0;
  always @(posedge clk) begin
    if (wr_pulse === 1'b1) pulses <= pulses + 1;
    if (sda_oe === 1'b1) oe_cycles <= oe_cycles + 1;
  end

  logic [7:0] mem_m [DEPTH];
  bit         known [DEPTH];
  int         ptr_m = 0;
  logic [7:0] wdata [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hdr(input logic r);
    return {4'b1010, addr_pins, r};
  endfunction

  task automatic i2c_start();
    sda_drv = 1'b1; #Q;
    scl = 1'b1; #Q;
    sda_drv = 1'b0; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; #Q;
    scl = 1'b1; #Q;
    sda_drv = 1'b1; #Q;
  endtask

  task automatic i2c_bit(input logic b, output logic s);
    sda_drv = b; #Q;
    scl = 1'b1; #Q;
    s = sda_bus; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
    i2c_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, s);
      d[i] = s;
    end
    i2c_bit(~mack, s);
  endtask

  task automatic send_addr(input int addr, input string tag);
    logic a;
    send_byte(8'(addr >> 8), a);
    chk({tag, "_adrh"}, 32'(a), 1);
    send_byte(8'(addr), a);
    chk({tag, "_adrl"}, 32'(a), 1);
    ptr_m = addr % DEPTH;
  endtask

  task automatic do_write(input int addr, input string tag,
                          input bit settle);
    logic a;
    int   p0;
    int   n;
    p0 = pulses;
    n = 0;
    i2c_start();
    send_byte(hdr(1'b0), a);
    chk({tag, "_dev"}, 32'(a), 1);
    send_addr(addr, tag);
    foreach (wdata[i]) begin
      send_byte(wdata[i], a);
      chk({tag, "_dack"}, 32'(a), 32'(!wp));
      if (wp) break;
      mem_m[ptr_m] = wdata[i];
      known[ptr_m] = 1'b1;
      ptr_m = ptr_m - ptr_m % PAGE + (ptr_m + 1) % PAGE;
      n++;
    end
    i2c_stop();
    #100;
    chk({tag, "_pulses"}, 32'(pulses - p0), 32'(n));
    chk({tag, "_ptr"}, 32'(ptr), 32'(ptr_m));
`ifdef WR_BUSY_EN
    if (settle && n > 0) #(BUSY * 10);
`else
    if (settle && n > 0) #10;
`endif
  endtask

  task automatic do_read(input bit rnd, input int addr, input int n,
                         input string tag);
    logic       a;
    logic [7:0] d;
    if (rnd) begin
      i2c_start();
      send_byte(hdr(1'b0), a);
      chk({tag, "_wdev"}, 32'(a), 1);
      send_addr(addr, tag);
    end
    i2c_start();
    send_byte(hdr(1'b1), a);
    chk({tag, "_rdev"}, 32'(a), 1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i < n - 1, d);
      if (known[ptr_m]) chk({tag, "_data"}, 32'(d), 32'(mem_m[ptr_m]));
      ptr_m = (ptr_m + 1) % DEPTH;
    end
    i2c_stop();
    #100;
    chk({tag, "_ptr"}, 32'(ptr), 32'(ptr_m));
  endtask

  initial begin
    logic a;
    logic s;
    int   oe0;
    int   p0;
    int   last_addr;

    #100;
    chk("rst_sda_oe", 32'(sda_oe), 0);
    chk("rst_wr_pulse", 32'(wr_pulse), 0);
    chk("rst_ptr", 32'(ptr), 0);
    rst = 1'b0;
    #100;

    wdata = '{8'h5A};
    do_write(16'h0123, "bw", 1'b1);
    do_read(1'b1, 16'h0123, 1, "rr");
    chk("rr_ptr_end", 32'(ptr), 32'h124);

    wdata = '{8'hC1, 8'hC2};
    do_write(16'h0040, "pre40", 1'b1);
    wdata.delete();
    for (int i = 0; i < 34; i++) wdata.push_back(8'(i));
    do_write(16'h003E, "pw", 1'b1);
    do_read(1'b1, 16'h003E, 4, "pr");
    do_read(1'b1, 16'h0020, 1, "pr20");

    wdata = '{8'h9F};
    do_write(16'h1FFF, "top", 1'b1);
    wdata = '{8'h11, 8'h22};
    do_write(16'h0000, "bot", 1'b1);
    do_read(1'b1, 16'h1FFF, 3, "rw");
    chk("rw_ptr_end", 32'(ptr), 2);

    oe0 = oe_cycles;
    i2c_start();
    send_byte(8'hA2, a);
    chk("mis_nack", 32'(a), 0);
    send_byte(8'h55, a);
    i2c_stop();
    #100;
    chk("mis_no_drive", 32'(oe_cycles - oe0), 0);

    addr_pins = 3'b101;
    wdata = '{8'h3C};
    do_write(16'h0777, "pins", 1'b1);
    do_read(1'b1, 16'h0777, 1, "pinsr");
    addr_pins = 3'b000;

    wp = 1'b1;
    wdata = '{8'hC3};
    do_write(16'h0123, "wp", 1'b1);
    wp = 1'b0;
    do_read(1'b1, 16'h0123, 1, "wpr");

    i2c_start();
    send_byte(hdr(1'b0), a);
    for (int i = 0; i < 4; i++) i2c_bit(1'b1, s);
    wdata = '{8'hE7};
    do_write(16'h0300, "rs", 1'b1);
    do_read(1'b1, 16'h0300, 1, "rsr");

    wdata = '{8'h66};
    do_write(16'h0100, "pre100", 1'b1);
    p0 = pulses;
    i2c_start();
    send_byte(hdr(1'b0), a);
    send_addr(16'h0100, "ra");
    for (int i = 7; i > 3; i--) i2c_bit(1'b1, s);
    sda_drv = 1'b1; #Q;
    scl = 1'b1; #Q;
    rst = 1'b1; #10;
    rst = 1'b0;
    chk("ra_sda_oe", 32'(sda_oe), 0);
    #(Q - 10);
    scl = 1'b0; #Q;
    i2c_stop();
    #100;
    ptr_m = 0;
    chk("ra_pulses", 32'(pulses - p0), 0);
    chk("ra_ptr", 32'(ptr), 32'(ptr_m));
    do_read(1'b1, 16'h0100, 1, "rar");

    wdata = '{8'h77};
    do_write(16'h0200, "bz", 1'b0);
    i2c_start();
    send_byte(hdr(1'b0), a);
`ifdef WR_BUSY_EN
    chk("bz_poll_nack", 32'(a), 0);
`else
    chk("bz_poll_ack", 32'(a), 1);
`endif
    i2c_stop();
    #(BUSY * 10);
    i2c_start();
    send_byte(hdr(1'b0), a);
    chk("bz_later_ack", 32'(a), 1);
    i2c_stop();
    #100;

    last_addr = 16'h0200;
    for (int k = 0; k < 10; k++) begin
      int op;
      int n;
      op = $urandom_range(0, 2);
      if (op == 0) begin
        last_addr = $urandom_range(0, DEPTH - 1);
        n = $urandom_range(1, 5);
        wdata.delete();
        for (int i = 0; i < n; i++) wdata.push_back(8'($urandom_range(0, 255)));
        do_write(last_addr, "rnd_w", 1'b1);
      end else if (op == 1) begin
        do_read(1'b1, last_addr, $urandom_range(1, 4), "rnd_r");
      end else begin
        ptr_m = int'(ptr);
        do_read(1'b0, 0, $urandom_range(1, 3), "rnd_c");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
